avst_avmm_mmio_master: RTL and testbench

AVST_AVMM_MMIO_MASTER -- requirements
Module: avst_avmm_mmio_master

---
 rtl/avmm_mmio_pkg.sv | 23 ++
 rtl/avmm_mmio_rsp_fifo.sv | 47 ++++
 rtl/avst_avmm_mmio_master.sv | 166 ++++++++++++++++
 tb/tb_avst_avmm_mmio_master.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/avmm_mmio_pkg.sv
// Shared types for the Avalon-ST to Avalon-MM MMIO master: command layout, FSM states, lane enables.
package avmm_mmio_pkg;

  localparam int PKG_ADDR_W = 16;
  localparam int PKG_DATA_W = 64;

  typedef struct packed {
    logic                  is_read;
    logic                  is_32bit;
    logic [PKG_ADDR_W-1:0] addr;
    logic [PKG_DATA_W-1:0] write_data;
  } t_avst_input;

  typedef enum logic {
    ST_IDLE,
    ST_CMD
  } t_state;

  localparam logic [7:0] BE_LANE_LO = 8'h0F;
  localparam logic [7:0] BE_LANE_HI = 8'hF0;
  localparam logic [7:0] BE_ALL     = 8'hFF;

endpackage

// File: rtl/avmm_mmio_rsp_fifo.sv
// Showahead synchronous FIFO for read responses; pop_data reads as zero while empty.
module avmm_mmio_rsp_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             not_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [NW-1:0]    count;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + NW'(push) - NW'(pop);
    end
  end

  // Storage needs no reset: the occupancy count alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign not_empty = (count != '0);
  assign pop_data  = not_empty ? mem[rd_ptr] : '0;

endmodule

// File: rtl/avst_avmm_mmio_master.sv
// Avalon-ST command stream to Avalon-MM master with credit-limited, in-order read responses.
// Optional read timeout is compiled in with `define AVMM_MMIO_RD_TIMEOUT_EN.
module avst_avmm_mmio_master
  import avmm_mmio_pkg::*;
#(
  parameter int AVMM_ADDR_WIDTH   = 16,
  parameter int AVMM_DATA_WIDTH   = 64,
  parameter int RSP_FIFO_DEPTH    = 64,
  parameter int RD_TIMEOUT_CYCLES = 4096
) (
  input  logic                                   clk,
  input  logic                                   SoftReset_n,
  input  logic [AVMM_ADDR_WIDTH+AVMM_DATA_WIDTH+1:0] in_data,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  output logic [AVMM_DATA_WIDTH-1:0]             out_data,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [AVMM_ADDR_WIDTH-1:0]             avmm_address,
  output logic                                   avmm_read,
  output logic                                   avmm_write,
  output logic [AVMM_DATA_WIDTH-1:0]             avmm_writedata,
  output logic [AVMM_DATA_WIDTH/8-1:0]           avmm_byteenable,
  input  logic                                   avmm_waitrequest,
  input  logic [AVMM_DATA_WIDTH-1:0]             avmm_readdata,
  input  logic                                   avmm_readdatavalid,
  output logic                                   rsp_err
);

  localparam int AW  = AVMM_ADDR_WIDTH;
  localparam int DW  = AVMM_DATA_WIDTH;
  localparam int BEW = DW / 8;
  localparam int CW  = $clog2(RSP_FIFO_DEPTH) + 1;

  if (DW != 64 || RD_TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("avst_avmm_mmio_master: only 64-bit data and RD_TIMEOUT_CYCLES >= 2 are supported");
  end

  logic          cmd_is_read;
  logic          cmd_is_32;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;

  assign cmd_is_read = in_data[AW+DW+1];
  assign cmd_is_32   = in_data[AW+DW];
  assign cmd_addr    = in_data[AW+DW-1:DW];
  assign cmd_wdata   = in_data[DW-1:0];

  t_state        state;
  logic [CW-1:0] credits;
  logic [CW-1:0] credits_next;
  logic [CW-1:0] outstanding;
  logic          acc;
  logic          rd_acc;
  logic          issue;
  logic          pop;
  logic          push;
  logic          ret;
  logic          rdv_err;
  logic [DW-1:0] push_data;

  assign acc    = in_valid && in_ready;
  assign rd_acc = acc && cmd_is_read;
  assign issue  = avmm_read && !avmm_waitrequest;
  assign pop    = out_valid && out_ready;

  always_comb credits_next = credits - CW'(rd_acc) + CW'(pop);

  function automatic logic [7:0] lane_be(input logic is32, input logic a2);
    if (!is32) return BE_ALL;
    return a2 ? BE_LANE_HI : BE_LANE_LO;
  endfunction

`ifdef AVMM_MMIO_RD_TIMEOUT_EN
  localparam int TW = $clog2(RD_TIMEOUT_CYCLES);

  logic [TW-1:0] timer;
  logic [CW-1:0] drop;
  logic          timeout;
  logic          rdv_take;
  logic          rdv_drop;

  assign timeout  = (outstanding != '0) && !avmm_readdatavalid &&
                    (timer == TW'(RD_TIMEOUT_CYCLES - 1));
  // A reply arriving while drop>0 belongs to a read already answered with all-ones.
  assign rdv_drop  = avmm_readdatavalid && (drop != '0);
  assign rdv_take  = avmm_readdatavalid && (drop == '0) && (outstanding != '0);
  assign rdv_err   = avmm_readdatavalid && (drop == '0) && (outstanding == '0);
  assign ret       = rdv_take || timeout;
  assign push      = ret;
  assign push_data = timeout ? '1 : avmm_readdata;

  always_ff @(posedge clk) begin
    if (!SoftReset_n) begin
      timer <= '0;
      drop  <= '0;
    end else begin
      if (avmm_readdatavalid || outstanding == '0 || timeout) timer <= '0;
      else                                                   timer <= timer + 1'b1;
      drop <= drop + CW'(timeout) - CW'(rdv_drop);
    end
  end
`else
  assign ret       = avmm_readdatavalid && (outstanding != '0);
  assign rdv_err   = avmm_readdatavalid && (outstanding == '0);
  assign push      = ret;
  assign push_data = avmm_readdata;
`endif

  always_ff @(posedge clk) begin
    if (!SoftReset_n) begin
      state           <= ST_IDLE;
      in_ready        <= 1'b0;
      avmm_read       <= 1'b0;
      avmm_write      <= 1'b0;
      avmm_address    <= '0;
      avmm_writedata  <= '0;
      avmm_byteenable <= '0;
      rsp_err         <= 1'b0;
      credits         <= CW'(RSP_FIFO_DEPTH);
      outstanding     <= '0;
    end else begin
      credits     <= credits_next;
      outstanding <= outstanding + CW'(issue) - CW'(ret);
      if (rdv_err) rsp_err <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (acc) begin
            state           <= ST_CMD;
            in_ready        <= 1'b0;
            avmm_read       <= cmd_is_read;
            avmm_write      <= !cmd_is_read;
            avmm_address    <= cmd_addr;
            avmm_writedata  <= cmd_wdata;
            avmm_byteenable <= BEW'(lane_be(cmd_is_32, cmd_addr[2]));
          end else begin
            in_ready <= (credits_next != '0);
          end
        end
        ST_CMD: begin
          if (!avmm_waitrequest) begin
            state      <= ST_IDLE;
            avmm_read  <= 1'b0;
            avmm_write <= 1'b0;
            in_ready   <= (credits_next != '0);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  avmm_mmio_rsp_fifo #(
    .WIDTH (DW),
    .DEPTH (RSP_FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (SoftReset_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (out_data),
    .not_empty (out_valid)
  );

endmodule

// File: tb/tb_avst_avmm_mmio_master.sv
// Directed bench for avst_avmm_mmio_master: vector table plus credit, error, reset and timeout sequences.
module tb_avst_avmm_mmio_master;
  import avmm_mmio_pkg::*;

  logic        clk = 1'b0;
  logic        SoftReset_n;
  logic [81:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] avmm_address;
  logic        avmm_read;
  logic        avmm_write;
  logic [63:0] avmm_writedata;
  logic [7:0]  avmm_byteenable;
  logic        avmm_waitrequest;
  logic [63:0] avmm_readdata;
  logic        avmm_readdatavalid;
  logic        rsp_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  avst_avmm_mmio_master #(
    .AVMM_ADDR_WIDTH   (16),
    .AVMM_DATA_WIDTH   (64),
    .RSP_FIFO_DEPTH    (64),
    .RD_TIMEOUT_CYCLES (16)
  ) dut (
    .clk                (clk),
    .SoftReset_n        (SoftReset_n),
    .in_data            (in_data),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .out_data           (out_data),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .avmm_address       (avmm_address),
    .avmm_read          (avmm_read),
    .avmm_write         (avmm_write),
    .avmm_writedata     (avmm_writedata),
    .avmm_byteenable    (avmm_byteenable),
    .avmm_waitrequest   (avmm_waitrequest),
    .avmm_readdata      (avmm_readdata),
    .avmm_readdatavalid (avmm_readdatavalid),
    .rsp_err            (rsp_err)
  );

  typedef struct {
    logic        vld;
    logic        rd;
    logic        b32;
    logic [15:0] addr;
    logic [63:0] wd;
    logic        wreq;
    logic        rdv;
    logic [63:0] rdat;
    logic        ordy;
    logic        e_irdy;
    logic        e_rd;
    logic        e_wr;
    logic [15:0] e_addr;
    logic [7:0]  e_be;
    logic [63:0] e_wd;
    logic        e_ov;
    logic [63:0] e_od;
  } vec_t;

  vec_t vt[13];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive_cmd(input logic vld, input logic rd, input logic b32,
                           input logic [15:0] a, input logic [63:0] d);
    t_avst_input c;
    c.is_read    = rd;
    c.is_32bit   = b32;
    c.addr       = a;
    c.write_data = d;
    in_data  = c;
    in_valid = vld;
  endtask

  // Waits (bounded) for in_ready, then lets the accepting edge pass.
  task automatic send(input logic rd, input logic b32, input logic [15:0] a, input logic [63:0] d);
    int n = 0;
    drive_cmd(1'b1, rd, b32, a, d);
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    chk("send_ready", in_ready, 1'b1);
    step();
    drive_cmd(1'b0, 1'b0, 1'b0, 16'h0, 64'h0);
  endtask

  task automatic read_and_return(input logic [15:0] a, input logic [63:0] d);
    send(1'b1, 1'b0, a, 64'h0);
    step();
    avmm_readdatavalid = 1'b1;
    avmm_readdata      = d;
    step();
    avmm_readdatavalid = 1'b0;
    avmm_readdata      = 64'h0;
  endtask

  function automatic logic [63:0] pat(input int i);
    return 64'hC0DE_0000_0000_0000 + 64'(i) * 64'h0001_0001;
  endfunction

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //     vld rd b32 addr     wd                      wreq rdv rdat                    ordy | irdy rd wr addr     be     wd                      ov od
    vt[0]  = '{1, 0, 0, 16'h0010, 64'h1122334455667788, 1, 0, 64'h0,                 0,     0, 0, 1, 16'h0010, 8'hFF, 64'h1122334455667788, 0, 64'h0};
    vt[1]  = '{0, 0, 0, 16'h0000, 64'h0,                1, 0, 64'h0,                 0,     0, 0, 1, 16'h0010, 8'hFF, 64'h1122334455667788, 0, 64'h0};
    vt[2]  = '{0, 0, 0, 16'h0000, 64'h0,                1, 0, 64'h0,                 0,     0, 0, 1, 16'h0010, 8'hFF, 64'h1122334455667788, 0, 64'h0};
    vt[3]  = '{0, 0, 0, 16'h0000, 64'h0,                1, 0, 64'h0,                 0,     0, 0, 1, 16'h0010, 8'hFF, 64'h1122334455667788, 0, 64'h0};
    vt[4]  = '{0, 0, 0, 16'h0000, 64'h0,                0, 0, 64'h0,                 0,     1, 0, 0, 16'h0010, 8'hFF, 64'h1122334455667788, 0, 64'h0};
    vt[5]  = '{1, 1, 1, 16'h0024, 64'h0,                0, 0, 64'h0,                 0,     0, 1, 0, 16'h0024, 8'hF0, 64'h0,                0, 64'h0};
    vt[6]  = '{0, 0, 0, 16'h0000, 64'h0,                0, 0, 64'h0,                 0,     1, 0, 0, 16'h0024, 8'hF0, 64'h0,                0, 64'h0};
    vt[7]  = '{0, 0, 0, 16'h0000, 64'h0,                0, 0, 64'h0,                 0,     1, 0, 0, 16'h0024, 8'hF0, 64'h0,                0, 64'h0};
    vt[8]  = '{0, 0, 0, 16'h0000, 64'h0,                0, 0, 64'h0,                 0,     1, 0, 0, 16'h0024, 8'hF0, 64'h0,                0, 64'h0};
    vt[9]  = '{0, 0, 0, 16'h0000, 64'h0,                0, 0, 64'h0,                 0,     1, 0, 0, 16'h0024, 8'hF0, 64'h0,                0, 64'h0};
    vt[10] = '{0, 0, 0, 16'h0000, 64'h0,                0, 0, 64'h0,                 0,     1, 0, 0, 16'h0024, 8'hF0, 64'h0,                0, 64'h0};
    vt[11] = '{0, 0, 0, 16'h0000, 64'h0,                0, 1, 64'hAABBCCDD00000000,  0,     1, 0, 0, 16'h0024, 8'hF0, 64'h0,                1, 64'hAABBCCDD00000000};
    vt[12] = '{0, 0, 0, 16'h0000, 64'h0,                0, 0, 64'h0,                 1,     1, 0, 0, 16'h0024, 8'hF0, 64'h0,                0, 64'h0};

    SoftReset_n        = 1'b0;
    out_ready          = 1'b0;
    avmm_waitrequest   = 1'b0;
    avmm_readdatavalid = 1'b0;
    avmm_readdata      = 64'h0;
    drive_cmd(1'b0, 1'b0, 1'b0, 16'h0, 64'h0);
    step();
    step();
    chk("rst in_ready", in_ready, 1'b0);
    chk("rst avmm_read", avmm_read, 1'b0);
    chk("rst avmm_write", avmm_write, 1'b0);
    chk("rst out_valid", out_valid, 1'b0);
    chk("rst rsp_err", rsp_err, 1'b0);
    chk("rst address", avmm_address, 16'h0);
    chk("rst byteenable", avmm_byteenable, 8'h00);
    chk("rst out_data", out_data, 64'h0);
    SoftReset_n = 1'b1;
    step();
    chk("rel in_ready", in_ready, 1'b1);

    for (int i = 0; i < 13; i++) begin
      drive_cmd(vt[i].vld, vt[i].rd, vt[i].b32, vt[i].addr, vt[i].wd);
      avmm_waitrequest   = vt[i].wreq;
      avmm_readdatavalid = vt[i].rdv;
      avmm_readdata      = vt[i].rdat;
      out_ready          = vt[i].ordy;
      step();
      chk($sformatf("v%0d in_ready", i), in_ready, vt[i].e_irdy);
      chk($sformatf("v%0d avmm_read", i), avmm_read, vt[i].e_rd);
      chk($sformatf("v%0d avmm_write", i), avmm_write, vt[i].e_wr);
      chk($sformatf("v%0d address", i), avmm_address, vt[i].e_addr);
      chk($sformatf("v%0d byteenable", i), avmm_byteenable, vt[i].e_be);
      chk($sformatf("v%0d writedata", i), avmm_writedata, vt[i].e_wd);
      chk($sformatf("v%0d out_valid", i), out_valid, vt[i].e_ov);
      chk($sformatf("v%0d out_data", i), out_data, vt[i].e_od);
    end
    drive_cmd(1'b0, 1'b0, 1'b0, 16'h0, 64'h0);
    avmm_waitrequest   = 1'b0;
    avmm_readdatavalid = 1'b0;
    out_ready          = 1'b0;
    step();

    // Exhaust all 64 credits with responses held in the buffer.
    for (int i = 0; i < 64; i++) read_and_return(16'(i * 8), pat(i));
    chk("credit0 in_ready", in_ready, 1'b0);
    drive_cmd(1'b1, 1'b0, 1'b0, 16'h0100, 64'hDEAD);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("credit0 write blocked %0d", i), avmm_write, 1'b0);
      chk($sformatf("credit0 in_ready %0d", i), in_ready, 1'b0);
    end
    drive_cmd(1'b0, 1'b0, 1'b0, 16'h0, 64'h0);
    chk("full out_valid", out_valid, 1'b1);
    chk("full head data", out_data, pat(0));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("credit1 in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    for (int k = 1; k < 64; k++) begin
      chk($sformatf("drain%0d out_valid", k), out_valid, 1'b1);
      chk($sformatf("drain%0d out_data", k), out_data, pat(k));
      step();
    end
    out_ready = 1'b0;
    chk("drained out_valid", out_valid, 1'b0);

    avmm_readdatavalid = 1'b1;
    avmm_readdata      = 64'h5555;
    step();
    avmm_readdatavalid = 1'b0;
    avmm_readdata      = 64'h0;
    chk("spurious rsp_err", rsp_err, 1'b1);
    chk("spurious out_valid", out_valid, 1'b0);
    step();
    step();
    step();
    chk("sticky rsp_err", rsp_err, 1'b1);

    for (int i = 0; i < 3; i++) read_and_return(16'h0200 + 16'(i * 8), pat(100 + i));
    chk("buffered out_valid", out_valid, 1'b1);
    avmm_waitrequest = 1'b1;
    send(1'b0, 1'b0, 16'h0300, 64'hFEEDFACECAFEBEEF);
    step();
    chk("midcmd avmm_write", avmm_write, 1'b1);
    SoftReset_n = 1'b0;
    step();
    chk("midrst in_ready", in_ready, 1'b0);
    chk("midrst avmm_write", avmm_write, 1'b0);
    chk("midrst avmm_read", avmm_read, 1'b0);
    chk("midrst out_valid", out_valid, 1'b0);
    chk("midrst rsp_err", rsp_err, 1'b0);
    chk("midrst address", avmm_address, 16'h0);
    chk("midrst writedata", avmm_writedata, 64'h0);
    chk("midrst byteenable", avmm_byteenable, 8'h00);
    chk("midrst out_data", out_data, 64'h0);
    chk("midrst credits", 64'(dut.credits), 64'd64);
    SoftReset_n      = 1'b1;
    avmm_waitrequest = 1'b0;
    step();
    chk("post-rst in_ready", in_ready, 1'b1);
    chk("post-rst out_valid", out_valid, 1'b0);

`ifdef AVMM_MMIO_RD_TIMEOUT_EN
    begin
      int n;
      send(1'b1, 1'b0, 16'h0040, 64'h0);
      step();
      n = 0;
      while (!out_valid && n < 100) begin
        step();
        n++;
      end
      chk("timeout latency", 64'(n), 64'd16);
      chk("timeout data", out_data, 64'hFFFF_FFFF_FFFF_FFFF);
      out_ready = 1'b1;
      step();
      out_ready          = 1'b0;
      avmm_readdatavalid = 1'b1;
      avmm_readdata      = 64'h1234;
      step();
      avmm_readdatavalid = 1'b0;
      avmm_readdata      = 64'h0;
      step();
      chk("late rsp out_valid", out_valid, 1'b0);
      chk("late rsp rsp_err", rsp_err, 1'b0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
